pwmc_multi: RTL and testbench
=============================

PWMC_MULTI -- requirements
Module: pwmc_multi

Interface
REQ-001 Parameter: WIDTH, default 8, bit width of period, duty and counter per channel.
REQ-002 Parameter: CHANNELS, default 2, number of independent H-bridge PWM channels.
REQ-003 Parameter: DEAD_TIME, default 4, clk_50 cycles of both-low on direction reversal or brake release (range 1..255).
REQ-004 clk_50  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 period_in  input  CHANNELS*WIDTH  per-channel period in clocks, channel i at bits [i*WIDTH +: WIDTH].
REQ-007 duty_in  input  CHANNELS*WIDTH  per-channel high time in clocks, same packing.
REQ-008 load  input  CHANNELS  per-channel strobe; captures period_in/duty_in into shadow registers.
REQ-009 direction  input  CHANNELS  requested direction; 1 = clockwise (motor_2 driven), 0 = anti-clockwise (motor_1 driven).
REQ-010 brake  input  CHANNELS  per-channel brake request, level sensitive.
REQ-011 pwmOutEnable  input  CHANNELS  per-channel output enable, level sensitive.
REQ-012 motor_1  output  CHANNELS  anti-clockwise bridge drive, registered.
REQ-013 motor_2  output  CHANNELS  clockwise bridge drive, registered.
REQ-014 period_end  output  CHANNELS  one-cycle pulse in the cycle the active period/duty reload.

Function
REQ-015 Each channel SHALL hold shadow (sh_per, sh_duty), active (per, duty), counter cnt, direction state dir_act, and FSM {RUN, DEAD, BRAKE}.
REQ-016 load[i]=1 SHALL copy inputs into shadow on that edge; repeated loads before reload: last one wins.
REQ-017 cnt SHALL count 0..per-1 and wrap to 0; at cnt==per-1 per/duty SHALL reload from shadow and period_end SHALL pulse.
REQ-018 per==0: cnt held 0, PWM level 0, reload and period_end every cycle.
REQ-019 PWM level pwm = (cnt < duty); duty>=per gives 100%; duty==0 gives 0%.
REQ-020 Outputs SHALL be registered: a cnt value appears on motor_x one clock later.
REQ-021 RUN: motor_2 = pwm & dir_act & pwmOutEnable; motor_1 = pwm & ~dir_act & pwmOutEnable.
REQ-022 RUN, direction != dir_act: go DEAD, both outputs 0 for exactly DEAD_TIME cycles, then dir_act <= direction, return RUN.
REQ-023 Direction toggling back during DEAD SHALL not restart the dead count; dir_act takes value sampled on DEAD exit; if it equals old dir_act no reversal occurs.
REQ-024 brake=1 in any state: go BRAKE next edge, motor_1=motor_2=1, overriding pwmOutEnable and DEAD.
REQ-025 brake falling: BRAKE -> DEAD (DEAD_TIME cycles, both 0), then RUN with dir_act <= direction.
REQ-026 pwmOutEnable=0 SHALL force both 0 in RUN only; cnt, reloads and period_end keep running, phase preserved.
REQ-027 cnt, reload and period_end SHALL run in all FSM states; BRAKE/DEAD never stall the counter.
REQ-028 Channels SHALL be fully independent; no cross-channel coupling.
REQ-029 motor_1 and motor_2 SHALL never both be 1 except in BRAKE.

Reset
REQ-030 reset=1 SHALL clear shadow, active per/duty, cnt, dir_act, motor_1, motor_2, period_end to 0 and FSM to RUN, on the next clk_50 edge.
REQ-031 reset SHALL override load, brake and direction in the same cycle; reset mid-DEAD or mid-BRAKE returns to RUN with outputs 0.
REQ-032 First cycle after reset release: per==0, so period_end pulses and shadow loaded during reset-release is taken immediately.

Verification (WIDTH=8, CHANNELS=2, DEAD_TIME=3)
REQ-033 ch0 load per=8 duty=5, dir=1, en=1 -> motor_2 high 5 cycles, low 3, repeating; motor_1 stays 0; period_end every 8 cycles.
REQ-034 mid-period load per=5 duty=3 -> old 5/8 pattern completes; new 3/5 starts right after period_end; no truncated pulse.
REQ-035 dir 1->0 while motor_2 high -> both 0 for exactly 3 cycles, then motor_1 carries PWM; cnt phase unchanged.
REQ-036 brake=1 with en=0 -> both 1 next cycle; brake released -> both 0 for 3 cycles, then PWM resumes per direction.
REQ-037 duty=0, duty=per=8, duty=200>per, per=0 -> constant 0, constant 1, constant 1, constant 0; ch1 driven concurrently with different values is unaffected.
REQ-038 reset asserted during DEAD with brake=1 -> next edge all outputs 0, FSM RUN, shadow and active cleared.

Source files
------------

// File: rtl/pwmc_multi.sv
// pwmc_multi: multi-channel H-bridge PWM controller.
// Every channel has its own shadow/active period and duty, a free-running
// counter, a dead-time generator for direction reversal or brake release,
// and a brake state that drives both bridge legs high.
module pwmc_multi #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned DEAD_TIME = 4
) (
  input  logic                      clk_50,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] period_in,
  input  logic [CHANNELS*WIDTH-1:0] duty_in,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS-1:0]       direction,
  input  logic [CHANNELS-1:0]       brake,
  input  logic [CHANNELS-1:0]       pwmOutEnable,
  output logic [CHANNELS-1:0]       motor_1,
  output logic [CHANNELS-1:0]       motor_2,
  output logic [CHANNELS-1:0]       period_end
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DEAD  = 2'd1,
    BRAKE = 2'd2
  } state_e;

  // Dead counter counts down from DEAD_TIME-1 to 0, so DEAD lasts DEAD_TIME cycles.
  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_TIME - 1);

  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
    logic [WIDTH-1:0] sh_per_q, sh_per_d;
    logic [WIDTH-1:0] sh_duty_q, sh_duty_d;
    logic [WIDTH-1:0] per_q, per_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [7:0]       dead_q, dead_d;
    logic             dir_act_q, dir_act_d;
    logic             motor_1_q, motor_1_d;
    logic             motor_2_q, motor_2_d;
    logic             period_end_q, period_end_d;
    state_e           state_q, state_d;
    logic             reload;
    logic             pwm;

    // Next-state: shadow capture, counter/reload, FSM and registered bridge drive.
    always_comb begin
      sh_per_d     = sh_per_q;
      sh_duty_d    = sh_duty_q;
      per_d        = per_q;
      duty_d       = duty_q;
      cnt_d        = cnt_q;
      dead_d       = dead_q;
      dir_act_d    = dir_act_q;
      state_d      = state_q;
      motor_1_d    = 1'b0;
      motor_2_d    = 1'b0;

      reload       = (per_q == '0) || (cnt_q == (per_q - WIDTH'(1)));
      pwm          = (per_q != '0) && (cnt_q < duty_q);
      period_end_d = reload;

      if (load[g]) begin
        sh_per_d  = period_in[g*WIDTH +: WIDTH];
        sh_duty_d = duty_in[g*WIDTH +: WIDTH];
      end

      if (reload) begin
        per_d  = sh_per_q;
        duty_d = sh_duty_q;
        cnt_d  = '0;
      end else begin
        cnt_d  = cnt_q + WIDTH'(1);
      end

      if (brake[g]) begin
        state_d = BRAKE;
      end else begin
        unique case (state_q)
          RUN: begin
            if (direction[g] != dir_act_q) begin
              state_d = DEAD;
              dead_d  = DEAD_LOAD;
            end
          end
          DEAD: begin
            if (dead_q == '0) begin
              state_d   = RUN;
              dir_act_d = direction[g];
            end else begin
              dead_d = dead_q - 8'd1;
            end
          end
          BRAKE: begin
            state_d = DEAD;
            dead_d  = DEAD_LOAD;
          end
          default: state_d = RUN;
        endcase
      end

      // Outputs follow the state being entered so brake/dead act on the same edge.
      if (state_d == BRAKE) begin
        motor_1_d = 1'b1;
        motor_2_d = 1'b1;
      end else if (state_d == RUN) begin
        motor_2_d = pwm & dir_act_d & pwmOutEnable[g];
        motor_1_d = pwm & ~dir_act_d & pwmOutEnable[g];
      end
    end

    // Channel state register with synchronous reset.
    always_ff @(posedge clk_50) begin
      if (reset) begin
        sh_per_q     <= '0;
        sh_duty_q    <= '0;
        per_q        <= '0;
        duty_q       <= '0;
        cnt_q        <= '0;
        dead_q       <= '0;
        dir_act_q    <= 1'b0;
        motor_1_q    <= 1'b0;
        motor_2_q    <= 1'b0;
        period_end_q <= 1'b0;
        state_q      <= RUN;
      end else begin
        sh_per_q     <= sh_per_d;
        sh_duty_q    <= sh_duty_d;
        per_q        <= per_d;
        duty_q       <= duty_d;
        cnt_q        <= cnt_d;
        dead_q       <= dead_d;
        dir_act_q    <= dir_act_d;
        motor_1_q    <= motor_1_d;
        motor_2_q    <= motor_2_d;
        period_end_q <= period_end_d;
        state_q      <= state_d;
      end
    end

    assign motor_1[g]    = motor_1_q;
    assign motor_2[g]    = motor_2_q;
    assign period_end[g] = period_end_q;
  end

endmodule

// File: tb/tb_pwmc_multi.sv
// tb_pwmc_multi: directed stimulus with a per-channel scoreboard of
// expected {motor_1, motor_2, period_end} keyed by clock cycle number.
module tb_pwmc_multi;

  logic        clk_50 = 1'b0;
  logic        reset;
  logic [15:0] period_in;
  logic [15:0] duty_in;
  logic [1:0]  load;
  logic [1:0]  direction;
  logic [1:0]  brake;
  logic [1:0]  pwmOutEnable;
  logic [1:0]  motor_1;
  logic [1:0]  motor_2;
  logic [1:0]  period_end;

  pwmc_multi #(
    .WIDTH(8),
    .CHANNELS(2),
    .DEAD_TIME(3)
  ) dut (
    .clk_50(clk_50),
    .reset(reset),
    .period_in(period_in),
    .duty_in(duty_in),
    .load(load),
    .direction(direction),
    .brake(brake),
    .pwmOutEnable(pwmOutEnable),
    .motor_1(motor_1),
    .motor_2(motor_2),
    .period_end(period_end)
  );

  always #5 clk_50 = ~clk_50;

  // Cycle n = outputs produced by the n-th rising edge, sampled on the following falling edge.
  int unsigned cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic        m1;
    logic        m2;
    logic        pe;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;

  localparam int M_ACW  = 0;
  localparam int M_CW   = 1;
  localparam int M_ZERO = 2;
  localparam int M_BRK  = 3;

  task automatic push_raw(input int ch, input int unsigned c, input logic m1, input logic m2,
                          input logic pe);
    exp_t e;
    e.cyc = c;
    e.m1  = m1;
    e.m2  = m2;
    e.pe  = pe;
    if (ch == 0) q0.push_back(e);
    else         q1.push_back(e);
  endtask

  // n consecutive cycles starting at c0; kstart is the counter value shown at c0.
  task automatic push_seg(input int ch, input int unsigned c0, input int kstart, input int n,
                          input int per, input int duty, input int mode);
    for (int i = 0; i < n; i++) begin
      int   k;
      logic lv;
      logic pe;
      if (per == 0) begin
        lv = 1'b0;
        pe = 1'b1;
      end else begin
        k  = (kstart + i) % per;
        lv = (k < duty);
        pe = (k == per - 1);
      end
      case (mode)
        M_ACW:   push_raw(ch, c0 + i, lv, 1'b0, pe);
        M_CW:    push_raw(ch, c0 + i, 1'b0, lv, pe);
        M_BRK:   push_raw(ch, c0 + i, 1'b1, 1'b1, pe);
        default: push_raw(ch, c0 + i, 1'b0, 1'b0, pe);
      endcase
    end
  endtask

  task automatic check_ch(input int ch);
    exp_t e;
    logic have;
    logic [2:0] act;
    forever begin
      have = 1'b0;
      if (ch == 0 && q0.size() > 0 && q0[0].cyc <= cyc) begin
        e = q0.pop_front();
        have = 1'b1;
      end else if (ch == 1 && q1.size() > 0 && q1[0].cyc <= cyc) begin
        e = q1.pop_front();
        have = 1'b1;
      end
      if (!have) break;
      tests++;
      act = {motor_1[ch], motor_2[ch], period_end[ch]};
      if (e.cyc != cyc) begin
        fails++;
        $display("FAIL stale ch%0d: entry for cycle %0d checked at cycle %0d", ch, e.cyc, cyc);
      end else if (act !== {e.m1, e.m2, e.pe}) begin
        fails++;
        $display("FAIL outputs ch%0d cycle %0d: got m1/m2/pe=%b required %b", ch, cyc, act,
                 {e.m1, e.m2, e.pe});
      end
    end
  endtask

  // Monitor: compare every due scoreboard entry on the falling edge.
  always @(negedge clk_50) begin
    check_ch(0);
    check_ch(1);
  end

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) @(negedge clk_50);
  endtask

  task automatic set_ch(input int ch, input logic [7:0] per, input logic [7:0] duty);
    period_in[ch*8 +: 8] = per;
    duty_in[ch*8 +: 8]   = duty;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned t;
    // Reset wins over load/brake/direction applied in the same cycles.
    reset        = 1'b1;
    load         = 2'b11;
    brake        = 2'b11;
    direction    = 2'b11;
    pwmOutEnable = 2'b11;
    set_ch(0, 8'd8, 8'd5);
    set_ch(1, 8'd8, 8'd5);
    for (int c = 1; c <= 2; c++) begin
      push_raw(0, c, 1'b0, 1'b0, 1'b0);
      push_raw(1, c, 1'b0, 1'b0, 1'b0);
    end
    wait_cyc(2);
    reset     = 1'b0;
    load      = 2'b00;
    brake     = 2'b00;
    direction = 2'b00;
    // Shadow cleared by reset: per stays 0, period_end every cycle, outputs low.
    push_seg(0, 3, 0, 3, 0, 0, M_ACW);
    push_seg(1, 3, 0, 3, 0, 0, M_ACW);
    wait_cyc(5);

    // 8/5 clockwise; first a dead interval because dir_act resets to 0.
    t = cyc;
    load[0]      = 1'b1;
    direction[0] = 1'b1;
    set_ch(0, 8'd8, 8'd5);
    push_raw(0, t + 1, 1'b0, 1'b0, 1'b1);
    push_raw(0, t + 2, 1'b0, 1'b0, 1'b1);
    push_raw(0, t + 3, 1'b0, 1'b0, 1'b0);
    push_seg(0, t + 4, 1, 31, 8, 5, M_CW);
    wait_cyc(t + 1);
    load[0] = 1'b0;

    // Two loads mid-period: the later one (5/3) is taken at the period boundary.
    wait_cyc(t + 29);
    load[0] = 1'b1;
    set_ch(0, 8'd6, 8'd1);
    wait_cyc(t + 30);
    set_ch(0, 8'd5, 8'd3);
    push_seg(0, t + 35, 0, 11, 5, 3, M_CW);
    wait_cyc(t + 31);
    load[0] = 1'b0;

    // Reverse while motor_2 high: 3 dead cycles, then motor_1 in the same phase.
    wait_cyc(t + 45);
    direction[0] = 1'b0;
    push_seg(0, t + 46, 1, 3, 5, 3, M_ZERO);
    push_seg(0, t + 49, 4, 12, 5, 3, M_ACW);

    // Enable off: outputs low, counter keeps running.
    wait_cyc(t + 60);
    pwmOutEnable[0] = 1'b0;
    push_seg(0, t + 61, 1, 5, 5, 3, M_ZERO);

    // Brake with enable off: both legs high.
    wait_cyc(t + 65);
    brake[0] = 1'b1;
    push_seg(0, t + 66, 1, 5, 5, 3, M_BRK);

    // Brake release: 3 dead cycles, then PWM resumes anti-clockwise.
    wait_cyc(t + 70);
    brake[0]        = 1'b0;
    pwmOutEnable[0] = 1'b1;
    push_seg(0, t + 71, 1, 3, 5, 3, M_ZERO);
    push_seg(0, t + 74, 4, 6, 5, 3, M_ACW);

    // Duty corner cases on ch0 while ch1 runs 4/1 clockwise.
    wait_cyc(t + 79);
    load         = 2'b11;
    direction[1] = 1'b1;
    set_ch(0, 8'd8, 8'd0);
    set_ch(1, 8'd4, 8'd1);
    push_seg(0, t + 80, 0, 5, 5, 3, M_ACW);
    push_seg(0, t + 85, 0, 8, 8, 0, M_ACW);
    push_seg(1, t + 80, 0, 2, 0, 0, M_ZERO);
    push_seg(1, t + 82, 0, 1, 4, 1, M_ZERO);
    push_seg(1, t + 83, 1, 28, 4, 1, M_CW);
    wait_cyc(t + 80);
    load = 2'b00;

    wait_cyc(t + 86);
    load[0] = 1'b1;
    set_ch(0, 8'd8, 8'd8);
    push_seg(0, t + 93, 0, 8, 8, 8, M_ACW);
    wait_cyc(t + 87);
    load[0] = 1'b0;

    wait_cyc(t + 94);
    load[0] = 1'b1;
    set_ch(0, 8'd8, 8'd200);
    push_seg(0, t + 101, 0, 8, 8, 200, M_ACW);
    wait_cyc(t + 95);
    load[0] = 1'b0;

    wait_cyc(t + 102);
    load[0] = 1'b1;
    set_ch(0, 8'd0, 8'd200);
    push_seg(0, t + 109, 0, 4, 0, 0, M_ACW);
    wait_cyc(t + 103);
    load[0] = 1'b0;

    // ch1 enters DEAD, then reset arrives together with brake.
    wait_cyc(t + 110);
    direction[1] = 1'b0;
    push_seg(1, t + 111, 1, 2, 4, 1, M_ZERO);
    wait_cyc(t + 112);
    reset = 1'b1;
    brake = 2'b11;
    for (int c = 113; c <= 114; c++) begin
      push_raw(0, t + c, 1'b0, 1'b0, 1'b0);
      push_raw(1, t + c, 1'b0, 1'b0, 1'b0);
    end
    wait_cyc(t + 114);
    reset     = 1'b0;
    brake     = 2'b00;
    direction = 2'b00;
    // Shadow and active registers cleared: per==0 behaviour on both channels.
    push_seg(0, t + 115, 0, 3, 0, 0, M_ACW);
    push_seg(1, t + 115, 0, 3, 0, 0, M_ACW);

    wait_cyc(t + 120);
    @(negedge clk_50);
    tests++;
    if (q0.size() + q1.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d scoreboard entries left unchecked, required 0",
               q0.size() + q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
